// File: rtl/vga_scanout.sv
// VGA timing generator with framebuffer scanout.
// Two-tick pipeline: address from counters, then word decode to pins.
module vga_scanout #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter bit H_POL        = 1'b0,
  parameter bit V_POL        = 1'b0,
  parameter int H_SCALE_LOG2 = 2,
  parameter int V_SCALE_LOG2 = 3,
  parameter int VRAM_AW      = 14
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clken,
  input  logic               mode,
  input  logic [VRAM_AW-1:0] base_addr,
  input  logic [11:0]        fg_color,
  input  logic [11:0]        bg_color,
  output logic [VRAM_AW-1:0] vram_raddr,
  input  logic [15:0]        vram_rdata,
  output logic               h_sync,
  output logic               v_sync,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue,
  output logic               frame_start,
  output logic               vblank
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int WPL0 = H_ACTIVE >> (1 + H_SCALE_LOG2);
  localparam int WPL1 = H_ACTIVE >> (4 + H_SCALE_LOG2);

  localparam logic [HW-1:0] HC_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_ON   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_OFF  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VC_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_ON   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_OFF  = VW'(V_ACTIVE + V_FP + V_SYNC);

  if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
      V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0 ||
      H_SCALE_LOG2 < 0 || V_SCALE_LOG2 < 0 ||
      VRAM_AW < 1 || VRAM_AW > 32 ||
      (H_ACTIVE % (16 << H_SCALE_LOG2)) != 0) begin : g_bad_cfg
    $error("vga_scanout: illegal configuration");
  end

  logic [HW-1:0]      hc;
  logic [VW-1:0]      vc;
  logic               mode_l;
  logic [VRAM_AW-1:0] base_l;
  logic               top;
  logic               mode_e;
  logic [VRAM_AW-1:0] base_e;
  logic               active;
  logic [31:0]        row;
  logic [31:0]        col;
  logic [3:0]         idx4;
  logic [3:0]         idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      hc <= '0;
      vc <= '0;
    end else if (clken) begin
      if (hc == HC_LAST) begin
        hc <= '0;
        vc <= (vc == VC_LAST) ? '0 : vc + VW'(1);
      end else begin
        hc <= hc + HW'(1);
      end
    end
  end

  // The first word of a frame already uses the freshly sampled settings.
  assign top    = (hc == '0) && (vc == '0);
  assign mode_e = top ? mode : mode_l;
  assign base_e = top ? base_addr : base_l;
  assign active = (hc < H_ACT) && (vc < V_ACT);

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_l <= mode;
      base_l <= base_addr;
    end else if (clken && top) begin
      mode_l <= mode;
      base_l <= base_addr;
    end
  end

  always_comb begin
    row  = 32'(vc) >> V_SCALE_LOG2;
    col  = 32'(hc) >> (mode_e ? 4 + H_SCALE_LOG2 : 1 + H_SCALE_LOG2);
    idx4 = 4'(hc >> H_SCALE_LOG2);
    idx  = mode_e ? idx4 : {3'b000, idx4[0]};
    vram_raddr = '0;
    if (active) begin
      vram_raddr = base_e + VRAM_AW'(row * (mode_e ? 32'(WPL1) : 32'(WPL0)) + col);
    end
  end

  logic       s1_act;
  logic       s1_mode;
  logic [3:0] s1_idx;
  logic       s1_hs;
  logic       s1_vs;
  logic       s1_fs;
  logic       s1_vb;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_act  <= 1'b0;
      s1_mode <= 1'b0;
      s1_idx  <= '0;
      s1_hs   <= ~H_POL;
      s1_vs   <= ~V_POL;
      s1_fs   <= 1'b0;
      s1_vb   <= 1'b0;
    end else if (clken) begin
      s1_act  <= active;
      s1_mode <= mode_e;
      s1_idx  <= idx;
      s1_hs   <= ((hc >= HS_ON) && (hc < HS_OFF)) ^ ~H_POL;
      s1_vs   <= ((vc >= VS_ON) && (vc < VS_OFF)) ^ ~V_POL;
      s1_fs   <= top;
      s1_vb   <= (vc >= V_ACT);
    end
  end

  logic [5:0]  px;
  logic        bit_on;
  logic [11:0] rgb;

  always_comb begin
    px     = s1_idx[0] ? vram_rdata[5:0] : vram_rdata[13:8];
    bit_on = vram_rdata[4'd15 - s1_idx];
    rgb    = '0;
    if (s1_act) begin
      if (s1_mode) begin
        rgb = bit_on ? fg_color : bg_color;
      end else begin
        rgb = {px[5:4], px[5:4], px[3:2], px[3:2], px[1:0], px[1:0]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_sync      <= ~H_POL;
      v_sync      <= ~V_POL;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      frame_start <= 1'b0;
      vblank      <= 1'b0;
    end else if (clken) begin
      h_sync      <= s1_hs;
      v_sync      <= s1_vs;
      {red, green, blue} <= rgb;
      frame_start <= s1_fs;
      vblank      <= s1_vb;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout with a shrunken raster so whole frames fit.
// Scoreboard model plus per-config address table.
module tb_vga_scanout;

  localparam int HA = 64, HFP = 4, HSY = 8, HBP = 4;
  localparam int VA = 16, VFP = 2, VSY = 2, VBP = 2;
  localparam int HSL = 2, VSL = 1, AW = 14;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       fs;
    logic       vb;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } out_t;

  typedef struct {
    logic          m;
    logic [AW-1:0] base;
    int            div;
    logic [11:0]   fg;
    logic [11:0]   bg;
    logic [AW-1:0] a0;
    logic [AW-1:0] al;
    logic [AW-1:0] ar;
  } vec_t;

  localparam out_t RST_OUT = '{hs: 1'b1, vs: 1'b1, fs: 1'b0, vb: 1'b0,
                               r: 4'h0, g: 4'h0, b: 4'h0};

  logic          clk = 1'b0;
  logic          reset;
  logic          clken;
  logic          mode;
  logic [AW-1:0] base_addr;
  logic [11:0]   fg_color;
  logic [11:0]   bg_color;
  logic [AW-1:0] vram_raddr;
  logic [15:0]   vram_rdata = '0;
  logic          h_sync, v_sync, frame_start, vblank;
  logic [3:0]    red, green, blue;

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .H_POL(1'b0), .V_POL(1'b0),
    .H_SCALE_LOG2(HSL), .V_SCALE_LOG2(VSL), .VRAM_AW(AW)
  ) dut (
    .clk(clk), .reset(reset), .clken(clken), .mode(mode),
    .base_addr(base_addr), .fg_color(fg_color), .bg_color(bg_color),
    .vram_raddr(vram_raddr), .vram_rdata(vram_rdata),
    .h_sync(h_sync), .v_sync(v_sync),
    .red(red), .green(green), .blue(blue),
    .frame_start(frame_start), .vblank(vblank)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] vword(input logic [AW-1:0] a);
    if (a == 14'd1) return 16'h2A15;
    if (a == 14'd5) return 16'h8001;
    return 16'(a * 16'd40503) ^ 16'h5A3C;
  endfunction

  // VRAM: one clken tick of read latency
  always @(posedge clk) if (clken) vram_rdata <= vword(vram_raddr);

  out_t cur, prev;
  assign cur = {h_sync, v_sync, frame_start, vblank, red, green, blue};

  out_t          exp_q[$];
  int            n_vec = 0, n_err = 0;
  int            mhc, mvc, ticks, fs_last, fs_cnt;
  logic          mml;
  logic [AW-1:0] mbl;
  bit            tbl_on;
  logic [AW-1:0] t_first, t_last, t_row1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    n_vec++;
    if (act !== ex) begin
      n_err++;
      $display("FAIL %s: got %h want %h (hc=%0d vc=%0d)", nm, act, ex, mhc, mvc);
    end
  endtask

  function automatic logic [AW-1:0] maddr(input int h, input int v,
                                          input logic m, input logic [AW-1:0] b);
    int sh;
    sh = (m ? 4 : 1) + HSL;
    if (h >= HA || v >= VA) return '0;
    return AW'(int'(b) + (v >> VSL) * (HA >> sh) + (h >> sh));
  endfunction

  function automatic out_t mexp(input int h, input int v,
                                input logic m, input logic [AW-1:0] b);
    out_t        e;
    logic [15:0] w;
    logic [5:0]  f;
    logic [11:0] c;
    int          idx;
    e.hs = !(h >= HA + HFP && h < HA + HFP + HSY);
    e.vs = !(v >= VA + VFP && v < VA + VFP + VSY);
    e.fs = (h == 0 && v == 0);
    e.vb = (v >= VA);
    c = '0;
    if (h < HA && v < VA) begin
      w = vword(maddr(h, v, m, b));
      if (m) begin
        idx = (h >> HSL) % 16;
        c = w[15-idx] ? fg_color : bg_color;
      end else begin
        idx = (h >> HSL) % 2;
        f = (idx == 0) ? w[13:8] : w[5:0];
        c = {f[5:4], f[5:4], f[3:2], f[3:2], f[1:0], f[1:0]};
      end
    end
    {e.r, e.g, e.b} = c;
    return e;
  endfunction

  task automatic step(input bit en);
    logic          em;
    logic [AW-1:0] eb;
    out_t          e;
    clken = en;
    if (en) begin
      em = (mhc == 0 && mvc == 0) ? mode : mml;
      eb = (mhc == 0 && mvc == 0) ? base_addr : mbl;
      chk("raddr", 32'(vram_raddr), 32'(maddr(mhc, mvc, em, eb)));
      if (tbl_on) begin
        if (mhc == 0 && mvc == 0) chk("tbl_first", 32'(vram_raddr), 32'(t_first));
        if (mhc == HA - 1 && mvc == 0) chk("tbl_last", 32'(vram_raddr), 32'(t_last));
        if (mhc == 0 && mvc == (1 << VSL)) chk("tbl_row1", 32'(vram_raddr), 32'(t_row1));
      end
      exp_q.push_back(mexp(mhc, mvc, em, eb));
      mml = em;
      mbl = eb;
      if (mhc == HT - 1) begin
        mhc = 0;
        mvc = (mvc == VT - 1) ? 0 : mvc + 1;
      end else begin
        mhc++;
      end
    end
    @(posedge clk);
    #1;
    if (en) begin
      ticks++;
      if (ticks == 1) chk("flush", 32'(cur), 32'(RST_OUT));
      if (exp_q.size() >= 2) begin
        e = exp_q.pop_front();
        chk("pix", 32'(cur), 32'(e));
      end
      if (cur.fs) begin
        if (fs_last >= 0) chk("fs_period", ticks - fs_last, HT * VT);
        else chk("fs_latency", ticks, 2);
        fs_last = ticks;
        fs_cnt++;
      end
    end else begin
      chk("hold", 32'(cur), 32'(prev));
    end
    prev = cur;
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    clken = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    chk("rst_out", 32'(cur), 32'(RST_OUT));
    @(negedge clk);
    reset = 1'b0;
    mhc = 0;
    mvc = 0;
    mml = mode;
    mbl = base_addr;
    exp_q.delete();
    ticks = 0;
    fs_last = -1;
    fs_cnt = 0;
    prev = cur;
  endtask

  vec_t vt[4];

  initial begin
    int cnt;
    vt[0] = '{1'b0, 14'd1,     1, 12'hFFF, 12'h000, 14'd1,     14'd8,   14'd9};
    vt[1] = '{1'b1, 14'd5,     1, 12'hF00, 12'h00F, 14'd5,     14'd5,   14'd6};
    vt[2] = '{1'b0, 14'd16383, 4, 12'h000, 12'hFFF, 14'd16383, 14'd6,   14'd7};
    vt[3] = '{1'b1, 14'd100,   2, 12'h0F0, 12'h123, 14'd100,   14'd100, 14'd101};
    reset = 1'b1;
    clken = 1'b0;
    mode = 1'b0;
    base_addr = '0;
    fg_color = '0;
    bg_color = '0;
    tbl_on = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      mode = vt[i].m;
      base_addr = vt[i].base;
      fg_color = vt[i].fg;
      bg_color = vt[i].bg;
      t_first = vt[i].a0;
      t_last = vt[i].al;
      t_row1 = vt[i].ar;
      tbl_on = 1'b1;
      do_reset(3);
      cnt = 0;
      while (ticks < HT * VT + 3) begin
        step(cnt % vt[i].div == 0);
        cnt++;
      end
      chk("fs_count", fs_cnt, 2);
    end
    tbl_on = 1'b0;

    // settings changed mid-frame must wait for the next frame
    mode = 1'b0;
    base_addr = 14'd1;
    fg_color = 12'hABC;
    bg_color = 12'h321;
    do_reset(2);
    while (!(mhc == 0 && mvc == 10)) step(1'b1);
    mode = 1'b1;
    base_addr = 14'd200;
    chk("mid_hold", 32'(vram_raddr), 32'd41);
    while (!(mhc == 0 && mvc == 0)) step(1'b1);
    chk("new_base", 32'(vram_raddr), 32'd200);
    cnt = 0;
    while (!(mhc == 0 && mvc == 12)) begin
      step(cnt % 3 == 0);
      cnt++;
    end

    // reset in the middle of the frame
    mode = 1'b0;
    base_addr = 14'd7;
    do_reset(1);
    chk("restart_addr", 32'(vram_raddr), 32'd7);
    for (int k = 0; k < 3 * HT; k++) step(1'b1);
    chk("restart_fs", fs_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
